// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, MEM-stage FSM states and the
// word-alignment helper used by the memory stage.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory request sequencer: IDLE/ACCESS state machine that holds the
// request stable from the EX/MEM register until the memory answers ready.
module dmem_access_fsm
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              op_load,
    input  logic              dmem_ready,
    input  logic              mem_write_p0,
    input  logic [DATA_W-1:0] addr_p0,
    input  logic [DATA_W-1:0] wdata_p0,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              stall
);

    mem_state_e state;
    mem_state_e state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // op_load only matters when EX/MEM actually loads: always in IDLE, and
    // in ACCESS only on the edge where the current access completes.
    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (op_load) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write_p0;
                stall    = ~dmem_ready;
                if (dmem_ready) begin
                    state_nxt = op_load ? ACCESS : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // EX/MEM holds while stalled, so address and data stay stable for free.
    assign dmem_addr  = addr_p0;
    assign dmem_wdata = wdata_p0;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM and MEM/WB registers around a data-memory access
// sequencer, with stall generation and misaligned-access detection.
module mem_stage
    import pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_write_data,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_mem_to_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] ex_mem_alu_result,
    output logic [REG_W-1:0]  ex_mem_write_reg,
    output logic              ex_mem_reg_write,
    output logic [DATA_W-1:0] mem_wb_write_data,
    output logic [REG_W-1:0]  mem_wb_write_reg,
    output logic              mem_wb_reg_write,
    output logic              stall,
    output logic              misalign_err
);

    logic              vld_p0;
    logic [DATA_W-1:0] alu_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [REG_W-1:0]  wreg_p0;
    logic              reg_write_p0;
    logic              mem_read_p0;
    logic              mem_write_p0;
    logic              mem_to_reg_p0;

    logic [DATA_W-1:0] wb_data_p1;
    logic [REG_W-1:0]  wreg_p1;
    logic              vld_p1;
    logic              misalign_p1;

    logic op_load;
    logic misaligned_p0;

    assign op_load = ex_valid && (ex_mem_read || ex_mem_write)
                     && !is_misaligned(ex_alu_result[1:0]);
    assign misaligned_p0 = vld_p0 && (mem_read_p0 || mem_write_p0)
                           && is_misaligned(alu_p0[1:0]);

    dmem_access_fsm u_fsm (
        .clk          (clk),
        .rst          (rst),
        .op_load      (op_load),
        .dmem_ready   (dmem_ready),
        .mem_write_p0 (mem_write_p0),
        .addr_p0      (alu_p0),
        .wdata_p0     (wdata_p0),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .stall        (stall)
    );

    // EX -> MEM boundary (p0)
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0        <= 1'b0;
            alu_p0        <= '0;
            wdata_p0      <= '0;
            wreg_p0       <= '0;
            reg_write_p0  <= 1'b0;
            mem_read_p0   <= 1'b0;
            mem_write_p0  <= 1'b0;
            mem_to_reg_p0 <= 1'b0;
        end else if (!stall) begin
            vld_p0        <= ex_valid;
            alu_p0        <= ex_alu_result;
            wdata_p0      <= ex_write_data;
            wreg_p0       <= ex_write_reg;
            reg_write_p0  <= ex_reg_write;
            mem_read_p0   <= ex_mem_read;
            mem_write_p0  <= ex_mem_write;
            mem_to_reg_p0 <= ex_mem_to_reg;
        end
    end

    // MEM -> WB boundary (p1); a stalled cycle inserts a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_p1  <= '0;
            wreg_p1     <= '0;
            vld_p1      <= 1'b0;
            misalign_p1 <= 1'b0;
        end else begin
            if (stall) begin
                vld_p1 <= 1'b0;
            end else begin
                wb_data_p1 <= mem_to_reg_p0 ? dmem_rdata : alu_p0;
                wreg_p1    <= wreg_p0;
                vld_p1     <= vld_p0 && reg_write_p0 && !misaligned_p0;
            end
            misalign_p1 <= !stall && misaligned_p0;
        end
    end

    assign ex_mem_alu_result = alu_p0;
    assign ex_mem_write_reg  = wreg_p0;
    assign ex_mem_reg_write  = reg_write_p0 && vld_p0 && !mem_read_p0;
    assign mem_wb_write_data = wb_data_p1;
    assign mem_wb_write_reg  = wreg_p1;
    assign mem_wb_reg_write  = vld_p1;
    assign misalign_err      = misalign_p1;

endmodule
